// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller: 4-entry request FIFO feeding a timed
// SETUP / EN PULSE / EXEC sequencer, preceded by a power-up wait and a 4-byte init.
module lcd_ctrl #(
  parameter int unsigned T_PWR  = 750000,
  parameter int unsigned T_SU   = 2,
  parameter int unsigned T_EN   = 25,
  parameter int unsigned T_EXEC = 2500,
  parameter int unsigned T_CLR  = 82000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_rs,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       init_done,
  output logic       busy,
  output logic [2:0] level,
  output logic       EN,
  output logic       RW,
  output logic       RS,
  output logic [7:0] data
);

  localparam logic [31:0] L_PWR_LAST  = 32'(T_PWR - 1);
  localparam logic [31:0] L_SU_LAST   = 32'(T_SU - 1);
  localparam logic [31:0] L_EN_LAST   = 32'(T_EN - 1);
  localparam logic [31:0] L_EXEC_LAST = 32'(T_EXEC - 1);
  localparam logic [31:0] L_CLR_LAST  = 32'(T_CLR - 1);

  typedef enum logic [2:0] {S_PWR, S_INIT, S_IDLE, S_SETUP, S_PULSE, S_EXEC} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_cnt;
  logic [1:0]  r_k;
  logic        r_init_done;
  logic        r_rs;
  logic [7:0]  r_data;
  logic [8:0]  r_fifo [4];
  logic [1:0]  r_wr_ptr, r_rd_ptr;
  logic [2:0]  r_count;

  logic        w_full, w_empty, w_push, w_pop;
  logic        w_load_init, w_k_inc, w_set_done;
  logic [7:0]  w_init_byte;
  logic [31:0] w_exec_last;
  logic [8:0]  w_head;

  assign w_full  = (r_count == 3'd4);
  assign w_empty = (r_count == 3'd0);
  assign w_push  = in_valid && !w_full;
  assign w_head  = r_fifo[r_rd_ptr];

  // Clear/home commands need the long execution wait.
  assign w_exec_last = (!r_rs && (r_data == 8'h01 || r_data == 8'h02)) ? L_CLR_LAST : L_EXEC_LAST;

  always_comb begin
    w_init_byte = 8'h38;
    case (r_k)
      2'd0:    w_init_byte = 8'h38;
      2'd1:    w_init_byte = 8'h0E;
      2'd2:    w_init_byte = 8'h01;
      default: w_init_byte = 8'h06;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load_init = 1'b0;
    w_k_inc     = 1'b0;
    w_set_done  = 1'b0;
    case (r_state)
      S_PWR:   if (r_cnt == L_PWR_LAST) w_state_nxt = S_INIT;
      S_INIT: begin
        w_load_init = 1'b1;
        w_state_nxt = S_SETUP;
      end
      S_IDLE: begin
        if (!w_empty && r_init_done) begin
          w_pop       = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: if (r_cnt == L_SU_LAST) w_state_nxt = S_PULSE;
      S_PULSE: if (r_cnt == L_EN_LAST) w_state_nxt = S_EXEC;
      S_EXEC: begin
        if (r_cnt == w_exec_last) begin
          w_state_nxt = S_IDLE;
          if (!r_init_done) begin
            if (r_k != 2'd3) begin
              w_k_inc     = 1'b1;
              w_state_nxt = S_INIT;
            end else begin
              w_set_done = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = S_PWR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_PWR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= (w_state_nxt != r_state) ? '0 : r_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k         <= '0;
      r_init_done <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= '0;
    end else begin
      if (w_load_init) begin
        r_rs   <= 1'b0;
        r_data <= w_init_byte;
      end else if (w_pop) begin
        r_rs   <= w_head[8];
        r_data <= w_head[7:0];
      end
      if (w_k_inc)    r_k         <= r_k + 2'd1;
      if (w_set_done) r_init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= {in_rs, in_byte};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign in_ready  = !w_full;
  assign init_done = r_init_done;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign level     = r_count;
  assign EN        = (r_state == S_PULSE);
  assign RW        = 1'b0;
  assign RS        = r_rs;
  assign data      = r_data;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl with short timing parameters: a pulse monitor checks each EN
// pulse against a queue of expected bytes; directed sequences check timing corners.
module tb_lcd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_rs = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready, init_done, busy, EN, RW, RS;
  logic [2:0] level;
  logic [7:0] data;

  lcd_ctrl #(.T_PWR(10), .T_SU(2), .T_EN(3), .T_EXEC(5), .T_CLR(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_rs(in_rs), .in_byte(in_byte),
    .in_ready(in_ready), .init_done(init_done), .busy(busy), .level(level),
    .EN(EN), .RW(RW), .RS(RS), .data(data)
  );

  always #5 clk = ~clk;

  typedef struct {logic rs; logic [7:0] data; int gap;} exp_t;
  typedef struct {logic rs; logic [7:0] b; int exec;} vec_t;

  exp_t sb[$];
  int   rise_log[$];
  int   fall_log[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  bit         in_pulse = 1'b0;
  bit         stable = 1'b1;
  int         rise_c = 0;
  int         last_fall = -1;
  logic       m_rs;
  logic [7:0] m_data;
  exp_t       e_mon;

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic add_exp(input logic rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.rs = rs;
    e.data = d;
    e.gap = gap;
    sb.push_back(e);
  endtask

  task automatic push_init_exp();
    add_exp(1'b0, 8'h38, -1);
    add_exp(1'b0, 8'h0E, 8);
    add_exp(1'b0, 8'h01, 8);
    add_exp(1'b0, 8'h06, 23);
  endtask

  task automatic wait_until(input int t);
    int g = 0;
    while (cyc < t && g < 500) begin
      tick();
      g++;
    end
  endtask

  task automatic wait_falls(input int n, input string nm);
    int g = 0;
    while (fall_log.size() < n && g < 500) begin
      tick();
      g++;
    end
    if (fall_log.size() < n) chk({nm, "_timeout"}, fall_log.size(), n);
  endtask

  task automatic wait_rises(input int n, input string nm);
    int g = 0;
    while (rise_log.size() < n && g < 500) begin
      tick();
      g++;
    end
    if (rise_log.size() < n) chk({nm, "_timeout"}, rise_log.size(), n);
  endtask

  task automatic wait_idle(input string nm);
    int g = 0;
    while (busy && g < 500) begin
      tick();
      g++;
    end
    if (busy) chk({nm, "_timeout"}, int'(busy), 0);
  endtask

  // Pulse monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst) begin
      in_pulse = 1'b0;
      last_fall = -1;
    end else if (EN && !in_pulse) begin
      in_pulse = 1'b1;
      rise_c = cyc;
      m_rs = RS;
      m_data = data;
      stable = 1'b1;
      rise_log.push_back(cyc);
    end else if (EN && in_pulse) begin
      if (RS !== m_rs || data !== m_data) stable = 1'b0;
    end else if (!EN && in_pulse) begin
      in_pulse = 1'b0;
      fall_log.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", 1, 0);
      end else begin
        e_mon = sb.pop_front();
        chk("pulse_rs", int'(m_rs), int'(e_mon.rs));
        chk("pulse_data", int'(m_data), int'(e_mon.data));
        chk("pulse_width", cyc - rise_c, 3);
        chk("pulse_stable", int'(stable), 1);
        if (e_mon.gap >= 0 && last_fall >= 0) chk("pulse_gap", rise_c - last_fall, e_mon.gap);
      end
      last_fall = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t uv[5];
    int r, n, fc, base;

    vecs[0] = '{1'b1, 8'h41, 5};
    vecs[1] = '{1'b0, 8'h01, 20};
    vecs[2] = '{1'b1, 8'h01, 5};
    vecs[3] = '{1'b0, 8'h02, 20};
    vecs[4] = '{1'b0, 8'h03, 5};
    vecs[5] = '{1'b1, 8'h02, 5};
    vecs[6] = '{1'b0, 8'h80, 5};

    uv[0] = '{1'b1, 8'h61, 0};
    uv[1] = '{1'b0, 8'h80, 0};
    uv[2] = '{1'b1, 8'h62, 0};
    uv[3] = '{1'b1, 8'h63, 0};
    uv[4] = '{1'b0, 8'hC0, 0};

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    chk("rst_en", int'(EN), 0);
    chk("rst_rs", int'(RS), 0);
    chk("rst_rw", int'(RW), 0);
    chk("rst_data", int'(data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_init_done", int'(init_done), 0);
    chk("rst_busy", int'(busy), 1);
    r = cyc;
    rst = 1'b0;
    push_init_exp();
    tick();
    chk("rdy_after_rst", int'(in_ready), 1);

    // Power-up init sequence
    wait_falls(4, "init");
    if (rise_log.size() >= 1) chk("first_rise", rise_log[0] - r, 13);
    fc = (fall_log.size() >= 4) ? fall_log[3] : cyc;
    wait_until(fc + 4);
    chk("init_done_early", int'(init_done), 0);
    tick();
    chk("init_done_set", int'(init_done), 1);
    chk("idle_busy", int'(busy), 0);

    // Single writes after init
    foreach (vecs[i]) begin
      base = fall_log.size();
      in_rs = vecs[i].rs;
      in_byte = vecs[i].b;
      in_valid = 1'b1;
      add_exp(vecs[i].rs, vecs[i].b, -1);
      tick();
      n = cyc;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_level", i), int'(level), 1);
      wait_falls(base + 1, $sformatf("vec%0d", i));
      if (rise_log.size() > base) chk($sformatf("vec%0d_rise", i), rise_log[base] - n, 3);
      fc = cyc;
      wait_idle($sformatf("vec%0d_idle", i));
      chk($sformatf("vec%0d_exec", i), cyc - fc, vecs[i].exec);
      tick();
    end

    // Fill the FIFO during the power-up wait, keep a fifth request pending
    rst = 1'b1;
    tick();
    tick();
    r = cyc;
    rst = 1'b0;
    sb.delete();
    rise_log.delete();
    fall_log.delete();
    push_init_exp();
    foreach (uv[i]) add_exp(uv[i].rs, uv[i].b, 8);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_rs = uv[i].rs;
      in_byte = uv[i].b;
      tick();
      chk($sformatf("fill_level%0d", i), int'(level), i + 1);
    end
    chk("full_rdy", int'(in_ready), 0);
    in_rs = uv[4].rs;
    in_byte = uv[4].b;
    tick();
    chk("fifth_refused", int'(level), 4);
    wait_until(r + 69);
    chk("hold_full", int'(level), 4);
    tick();
    chk("pop_no_push", int'(level), 3);
    chk("rdy_after_pop", int'(in_ready), 1);
    tick();
    chk("push_after_pop", int'(level), 4);
    in_valid = 1'b0;
    wait_falls(9, "queued");
    if (rise_log.size() >= 9) begin
      chk("first_user_rise", rise_log[4] - r, 72);
      for (int k = 4; k < 8; k++) chk($sformatf("pop_spacing%0d", k), rise_log[k + 1] - rise_log[k], 11);
    end
    wait_idle("queued_idle");
    tick();

    // Reset during the second pulse of a character burst
    rise_log.delete();
    fall_log.delete();
    add_exp(1'b1, 8'h71, -1);
    add_exp(1'b1, 8'h72, 8);
    add_exp(1'b1, 8'h73, 8);
    add_exp(1'b1, 8'h74, 8);
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_rs = 1'b1;
      in_byte = 8'h71 + 8'(i);
      tick();
    end
    in_valid = 1'b0;
    wait_rises(2, "burst");
    chk("pre_rst_level", int'(level), 2);
    chk("pre_rst_en", int'(EN), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_en", int'(EN), 0);
    chk("mid_rst_level", int'(level), 0);
    chk("mid_rst_init_done", int'(init_done), 0);
    r = cyc;
    rst = 1'b0;
    sb.delete();
    rise_log.delete();
    fall_log.delete();
    push_init_exp();
    wait_falls(4, "reinit");
    if (rise_log.size() >= 1) chk("reinit_first_rise", rise_log[0] - r, 13);
    wait_idle("reinit_idle");
    chk("reinit_done", int'(init_done), 1);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
